// File: rtl/ucsbece154b_gshare_bp.sv
// gshare direction predictor with a direct-mapped BTB and checkpointed GHR recovery.
// Optional statistics counters are enabled with the UCSBECE154B_BP_STATS_EN macro.
module ucsbece154b_gshare_bp #(
  parameter int BTB_IDX_BITS = 5,
  parameter int GHR_BITS     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pcF_i,
  input  logic                stallF_i,
  output logic                predict_taken_o,
  output logic [31:0]         predict_target_o,
  output logic [GHR_BITS-1:0] predict_ghr_o,
  input  logic                update_valid_i,
  input  logic                update_is_branch_i,
  input  logic                update_is_jump_i,
  input  logic [31:0]         update_pc_i,
  input  logic [31:0]         update_target_i,
  input  logic                update_taken_i,
  input  logic [GHR_BITS-1:0] update_ghr_i,
  input  logic                mispredict_i
`ifdef UCSBECE154B_BP_STATS_EN
  ,
  output logic [31:0]         stat_total_o,
  output logic [31:0]         stat_correct_o,
  output logic [31:0]         stat_mispredict_o
`endif
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int PHT_ENTRIES = 1 << GHR_BITS;
  localparam int TAG_BITS    = 30 - BTB_IDX_BITS;

  logic                    btb_valid_q  [BTB_ENTRIES];
  logic [TAG_BITS-1:0]     btb_tag_q    [BTB_ENTRIES];
  logic [31:0]             btb_target_q [BTB_ENTRIES];
  logic                    btb_jump_q   [BTB_ENTRIES];
  logic [1:0]              pht_q        [PHT_ENTRIES];
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;

  // Fetch-side lookup
  logic [BTB_IDX_BITS-1:0] f_btb_idx;
  logic [TAG_BITS-1:0]     f_tag;
  logic [GHR_BITS-1:0]     f_pht_idx;
  logic                    f_hit, f_dir;

  assign f_btb_idx = pcF_i[BTB_IDX_BITS+1:2];
  assign f_tag     = pcF_i[31:BTB_IDX_BITS+2];
  assign f_pht_idx = pcF_i[GHR_BITS+1:2] ^ ghr_q;
  assign f_hit     = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign f_dir     = pht_q[f_pht_idx][1];

  assign predict_taken_o  = f_hit && (btb_jump_q[f_btb_idx] || f_dir);
  assign predict_target_o = predict_taken_o ? btb_target_q[f_btb_idx] : pcF_i + 32'd4;
  assign predict_ghr_o    = ghr_q;

  // Execute-side update
  logic [BTB_IDX_BITS-1:0] u_btb_idx;
  logic [TAG_BITS-1:0]     u_tag;
  logic [GHR_BITS-1:0]     u_pht_idx;
  logic [1:0]              u_ctr, u_ctr_d;
  logic                    pht_we, btb_we, recover;
  logic                    unused_pc_bits;

  assign u_btb_idx      = update_pc_i[BTB_IDX_BITS+1:2];
  assign u_tag          = update_pc_i[31:BTB_IDX_BITS+2];
  assign u_pht_idx      = update_pc_i[GHR_BITS+1:2] ^ update_ghr_i;
  assign u_ctr          = pht_q[u_pht_idx];
  assign pht_we         = update_valid_i && update_is_branch_i;
  assign btb_we         = update_valid_i && update_taken_i;
  assign recover        = update_valid_i && mispredict_i;
  assign unused_pc_bits = ^update_pc_i[1:0];

  // Saturating 2-bit counter step
  always_comb begin
    u_ctr_d = u_ctr;
    if (update_taken_i) begin
      if (u_ctr != 2'b11) u_ctr_d = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'b00) u_ctr_d = u_ctr - 2'd1;
    end
  end

  // Truncating the concatenation drops the oldest bit and also works when GHR_BITS is 1.
  always_comb begin
    // NOTE: default assignment first so every path drives ghr_d and no latch is inferred.
    ghr_d = ghr_q;
    if (recover) begin
      if (update_is_jump_i) ghr_d = update_ghr_i;
      else                  ghr_d = GHR_BITS'({update_ghr_i, update_taken_i});
    end else if (!stallF_i && f_hit && !btb_jump_q[f_btb_idx]) begin
      ghr_d = GHR_BITS'({ghr_q, f_dir});
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (pht_we) pht_q[u_pht_idx] <= u_ctr_d;
      if (btb_we) btb_valid_q[u_btb_idx] <= 1'b1;
    end
  end

  // NOTE: BTB payload is not reset; the cleared valid bit masks whatever it holds.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[u_btb_idx]    <= u_tag;
      btb_target_q[u_btb_idx] <= update_target_i;
      btb_jump_q[u_btb_idx]   <= update_is_jump_i;
    end
  end

`ifdef UCSBECE154B_BP_STATS_EN
  logic [31:0] stat_total_q, stat_correct_q, stat_mispredict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_total_q      <= '0;
      stat_correct_q    <= '0;
      stat_mispredict_q <= '0;
    end else if (update_valid_i) begin
      stat_total_q <= stat_total_q + 32'd1;
      if (mispredict_i) stat_mispredict_q <= stat_mispredict_q + 32'd1;
      else              stat_correct_q    <= stat_correct_q + 32'd1;
    end
  end

  assign stat_total_o      = stat_total_q;
  assign stat_correct_o    = stat_correct_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_gshare_bp.sv
// Self-checking bench for ucsbece154b_gshare_bp: directed scenarios with literal
// expectations followed by random traffic compared against a table-level model.
module tb_ucsbece154b_gshare_bp;

  localparam int BI = 5;
  localparam int GB = 5;
  localparam int NB = 1 << BI;
  localparam int NP = 1 << GB;

  logic          clk, reset;
  logic [31:0]   pcF_i;
  logic          stallF_i;
  logic          predict_taken_o;
  logic [31:0]   predict_target_o;
  logic [GB-1:0] predict_ghr_o;
  logic          update_valid_i, update_is_branch_i, update_is_jump_i;
  logic [31:0]   update_pc_i, update_target_i;
  logic          update_taken_i;
  logic [GB-1:0] update_ghr_i;
  logic          mispredict_i;
`ifdef UCSBECE154B_BP_STATS_EN
  logic [31:0]   stat_total, stat_correct, stat_mispredict;
`endif

  ucsbece154b_gshare_bp #(.BTB_IDX_BITS(BI), .GHR_BITS(GB)) dut (
`ifdef UCSBECE154B_BP_STATS_EN
    .stat_total_o      (stat_total),
    .stat_correct_o    (stat_correct),
    .stat_mispredict_o (stat_mispredict),
`endif
    .clk                (clk),
    .reset              (reset),
    .pcF_i              (pcF_i),
    .stallF_i           (stallF_i),
    .predict_taken_o    (predict_taken_o),
    .predict_target_o   (predict_target_o),
    .predict_ghr_o      (predict_ghr_o),
    .update_valid_i     (update_valid_i),
    .update_is_branch_i (update_is_branch_i),
    .update_is_jump_i   (update_is_jump_i),
    .update_pc_i        (update_pc_i),
    .update_target_i    (update_target_i),
    .update_taken_i     (update_taken_i),
    .update_ghr_i       (update_ghr_i),
    .mispredict_i       (mispredict_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tables as plain arrays, counters as integers 0..3.
  bit          m_valid [NB];
  int unsigned m_tag [NB];
  int unsigned m_target [NB];
  bit          m_jump [NB];
  int          m_pht [NP];
  int unsigned m_ghr;
  int unsigned m_total, m_correct, m_misp;
  bit          chk_en = 1'b0;

  function automatic void m_look(input int unsigned pc, output bit hit, output bit jmp,
                                 output bit dir, output int unsigned idx);
    idx = (pc >> 2) % NB;
    hit = m_valid[idx] && (m_tag[idx] == (pc >> (BI + 2)));
    jmp = m_jump[idx];
    dir = m_pht[((pc >> 2) % NP) ^ m_ghr] >= 2;
  endfunction

  always @(posedge clk) begin
    bit hit, jmp, dir;
    int unsigned idx, nghr, pidx;
    if (reset) begin
      for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < NP; i++) m_pht[i] = 1;
      m_ghr = 0; m_total = 0; m_correct = 0; m_misp = 0;
      chk_en = 1'b1;
    end else begin
      m_look(pcF_i, hit, jmp, dir, idx);
      nghr = m_ghr;
      if (!stallF_i && hit && !jmp) nghr = ((m_ghr << 1) | dir) % NP;
      if (update_valid_i && mispredict_i)
        nghr = update_is_jump_i ? update_ghr_i : ((update_ghr_i << 1) | update_taken_i) % NP;
      if (update_valid_i && update_is_branch_i) begin
        pidx = ((update_pc_i >> 2) % NP) ^ update_ghr_i;
        if (update_taken_i) m_pht[pidx] = (m_pht[pidx] == 3) ? 3 : m_pht[pidx] + 1;
        else                m_pht[pidx] = (m_pht[pidx] == 0) ? 0 : m_pht[pidx] - 1;
      end
      if (update_valid_i && update_taken_i) begin
        idx = (update_pc_i >> 2) % NB;
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = update_pc_i >> (BI + 2);
        m_target[idx] = update_target_i;
        m_jump[idx]   = update_is_jump_i;
      end
      if (update_valid_i) begin
        m_total++;
        if (mispredict_i) m_misp++; else m_correct++;
      end
      m_ghr = nghr;
    end
  end

  // Single compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk) begin
    bit hit, jmp, dir, tk;
    int unsigned idx;
    if (chk_en) begin
      m_look(pcF_i, hit, jmp, dir, idx);
      tk = hit && (jmp || dir);
      check("model_taken", {31'd0, predict_taken_o}, {31'd0, tk});
      check("model_target", predict_target_o, tk ? m_target[idx] : pcF_i + 32'd4);
      check("model_ghr", {27'd0, predict_ghr_o}, m_ghr);
`ifdef UCSBECE154B_BP_STATS_EN
      check("model_total", stat_total, m_total);
      check("model_correct", stat_correct, m_correct);
      check("model_misp", stat_mispredict, m_misp);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    update_valid_i = 0; update_is_branch_i = 0; update_is_jump_i = 0;
    update_pc_i = 0; update_target_i = 0; update_taken_i = 0;
    update_ghr_i = '0; mispredict_i = 0;
  endtask

  task automatic upd(input bit jump, input logic [31:0] pc, input logic [31:0] tgt,
                     input bit taken, input logic [GB-1:0] ghr, input bit mp);
    update_valid_i = 1; update_is_branch_i = !jump; update_is_jump_i = jump;
    update_pc_i = pc; update_target_i = tgt; update_taken_i = taken;
    update_ghr_i = ghr; mispredict_i = mp;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    tick();
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit exp_nt [4];
    exp_nt[0] = 1; exp_nt[1] = 0; exp_nt[2] = 0; exp_nt[3] = 0;
    reset = 1; stallF_i = 1; pcF_i = 32'h100; idle();
    tick(); tick();
    reset = 0;
    #2;
    check("rst_taken", {31'd0, predict_taken_o}, 32'd0);
    check("rst_target", predict_target_o, 32'h104);
    check("rst_ghr", {27'd0, predict_ghr_o}, 32'd0);

    // Train branch at 0x100, then probe its alias 0x180
    upd(0, 32'h100, 32'h80, 1, 5'd0, 0); tick(); idle(); pcF_i = 32'h100; #2;
    check("train_taken", {31'd0, predict_taken_o}, 32'd1);
    check("train_target", predict_target_o, 32'h80);
    pcF_i = 32'h180; #1;
    check("alias_taken", {31'd0, predict_taken_o}, 32'd0);
    check("alias_target", predict_target_o, 32'h184);

    // Drive counter to 11 (twice, to exercise the top bound), then walk it down
    upd(0, 32'h100, 32'h80, 1, 5'd0, 0); tick();
    upd(0, 32'h100, 32'h80, 1, 5'd0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      upd(0, 32'h100, 32'h0, 0, 5'd0, 0); tick(); idle(); pcF_i = 32'h100; #2;
      check($sformatf("sat_nt%0d", i), {31'd0, predict_taken_o}, {31'd0, exp_nt[i]});
    end
    upd(0, 32'h100, 32'h80, 1, 5'd0, 0); tick(); idle(); #2;
    check("sat_floor", {31'd0, predict_taken_o}, 32'd0);
    upd(0, 32'h100, 32'h0, 0, 5'd0, 0); tick();

    // Jump overwrites the shared BTB slot; predicted taken despite counter 00
    upd(1, 32'h200, 32'h40, 1, 5'd0, 0); tick(); idle(); pcF_i = 32'h200; #2;
    check("jump_taken", {31'd0, predict_taken_o}, 32'd1);
    check("jump_target", predict_target_o, 32'h40);
    pcF_i = 32'h100; #1;
    check("evicted_taken", {31'd0, predict_taken_o}, 32'd0);
    check("evicted_target", predict_target_o, 32'h104);

    // Recovery: build GHR 00111 from speculative hits, then restore from a snapshot
    do_reset();
    upd(0, 32'h104, 32'h300, 1, 5'd0, 0); tick();
    upd(0, 32'h104, 32'h300, 1, 5'd1, 0); tick();
    upd(0, 32'h104, 32'h300, 1, 5'd3, 0); tick();
    idle(); stallF_i = 0; pcF_i = 32'h104; #2;
    check("spec_ghr0", {27'd0, predict_ghr_o}, 32'd0);
    tick(); #2; check("spec_ghr1", {27'd0, predict_ghr_o}, 32'd1);
    tick(); #2; check("spec_ghr3", {27'd0, predict_ghr_o}, 32'd3);
    tick(); #2; check("spec_ghr7", {27'd0, predict_ghr_o}, 32'd7);
    upd(0, 32'h104, 32'h0, 0, 5'b00010, 1);
    tick(); idle(); stallF_i = 1; #2;
    check("recover_ghr", {27'd0, predict_ghr_o}, 32'd4);

`ifdef UCSBECE154B_BP_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      upd(0, 32'h100, 32'h0, 0, 5'd0, (i == 0 || i == 2)); tick();
    end
    idle(); #2;
    check("stat_total", stat_total, 32'd5);
    check("stat_correct", stat_correct, 32'd3);
    check("stat_misp", stat_mispredict, 32'd2);
    do_reset(); #2;
    check("stat_rst_total", stat_total, 32'd0);
    check("stat_rst_correct", stat_correct, 32'd0);
    check("stat_rst_misp", stat_mispredict, 32'd0);
`endif

    // Random traffic over a small aliasing PC pool
    for (int c = 0; c < 3000; c++) begin
      bit jmp;
      reset    = ($urandom_range(0, 199) == 0);
      stallF_i = ($urandom_range(0, 3) == 0);
      pcF_i    = 32'h1000 | ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 7);
      if ($urandom_range(0, 1) == 1) begin
        jmp = ($urandom_range(0, 4) == 0);
        upd(jmp, 32'h1000 | ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 7),
            $urandom & 32'hFFFF_FFFC, jmp ? 1'b1 : 1'($urandom_range(0, 1)),
            GB'($urandom_range(0, NP - 1)), ($urandom_range(0, 3) == 0));
      end else begin
        idle();
        mispredict_i = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    reset = 0; idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_gshare_bp.md
# ucsbece154b_gshare_bp

Parametrised gshare branch predictor with a direct-mapped branch target buffer (BTB) and checkpointed global-history recovery.
- Sits beside the pipelined datapath. Fetch gets a same-cycle direction, target and history snapshot. Execute returns the resolved outcome.
- On a mispredict, the global history register (GHR) is restored from the snapshot that travelled with the instruction, instead of being cleared.

## Interface
Parameters:
- BTB_IDX_BITS, 5, log2 of BTB entries (legal 2..10).
- GHR_BITS, 5, history length; the pattern history table (PHT) has 2^GHR_BITS 2-bit counters (legal 1..12).

Ports (clock is clk, reset is reset; one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- pcF_i  in  32  fetch PC.
- stallF_i  in  1  fetch stalled; suppresses speculative GHR shift.
- predict_taken_o  out  1  fetch prediction: redirect to predict_target_o.
- predict_target_o  out  32  BTB target if predict_taken_o, else pcF_i+4.
- predict_ghr_o  out  GHR_BITS  GHR value used for this lookup; pipelined to execute by the datapath.
- update_valid_i  in  1  resolved control instruction in execute.
- update_is_branch_i  in  1  conditional branch.
- update_is_jump_i  in  1  jal/jalr.
- update_pc_i  in  32  PC of resolved instruction.
- update_target_i  in  32  resolved target.
- update_taken_i  in  1  resolved direction (1 for jumps).
- update_ghr_i  in  GHR_BITS  snapshot carried from fetch.
- mispredict_i  in  1  datapath detected mispredict this cycle.

## Operation
Address decomposition:
- BTB index = pc[BTB_IDX_BITS+1:2].
- BTB tag = pc[31:BTB_IDX_BITS+2].
- Each BTB entry holds {valid, tag, target[31:0], is_jump}.

Lookup (combinational):
- PHT index = pc[GHR_BITS+1:2] XOR GHR.
- hit = valid & tag match.
- predict_taken_o = hit & (is_jump | pht[idx][1]).
- predict_ghr_o = current GHR.

Speculative history:
- Condition: !stallF_i & hit & !is_jump.
- Action: GHR <= {GHR[GHR_BITS-2:0], pht[idx][1]}.

Recovery: if update_valid_i & mispredict_i, then next cycle:
- Branch: GHR = {update_ghr_i[GHR_BITS-2:0], update_taken_i}.
- Jump: GHR = update_ghr_i.
- Recovery has priority over the same-cycle speculative shift, which is discarded.

PHT training, on update_valid_i & update_is_branch_i:
- Counter at index update_pc_i[GHR_BITS+1:2] XOR update_ghr_i saturates toward taken or not taken.
- Saturation bounds: 11 stays 11 on taken; 00 stays 00 on not-taken.

BTB allocation:
- Condition: update_valid_i & update_taken_i (branch or jump).
- Writes valid=1, tag, target=update_target_i, is_jump=update_is_jump_i.
- Overwrites on alias.
- Not-taken updates never touch the BTB.

Illegal input: update_is_branch_i & update_is_jump_i both set is illegal; behaviour is unspecified.

## Timing
- Prediction: zero-cycle, combinational from pcF_i and registered state.
- All writes (BTB, PHT, GHR, counters) take effect at the next rising edge.
- Same-cycle lookup and update to the same entry: the lookup sees the old contents.
- Reset (any cycle, including mid-stream): at the next edge:
  - all BTB valid bits = 0;
  - all PHT counters = 01 (weakly not-taken);
  - GHR = 0;
  - counters = 0.
- Outputs after reset: predict_taken_o=0, predict_target_o=pcF_i+4, predict_ghr_o=0.
- Reset has priority over update and speculative shift.
- stallF_i gates only the GHR shift. Updates still apply during stalls.

## Configuration
- Macro: UCSBECE154B_BP_STATS_EN.
- When defined, adds three outputs:
  - stat_total_o  32  counts update_valid_i cycles.
  - stat_correct_o  32  counts update_valid_i & !mispredict_i.
  - stat_mispredict_o  32  counts update_valid_i & mispredict_i.
- Counter behaviour: increment at the clock edge, wrap at 2^32, clear on reset.
- When undefined: these ports and their registers do not exist. Predictor behaviour is identical either way.

## Test plan
All tests use default parameters.
- Reset then pcF_i=0x100 -> predict_taken_o=0, predict_target_o=0x104, predict_ghr_o=0.
- Branch training, then alias:
  - Update branch pc=0x100, taken, target 0x80, ghr 0, mispredict_i=0 -> next cycle pcF_i=0x100 gives taken, target 0x80.
  - pcF_i=0x180 (same index, different tag) -> not taken, target 0x184.
- Jump: update jump pc=0x200, target 0x40 -> lookup 0x200 predicts taken at 0x40, even with PHT counter 00.
- Saturation: four not-taken updates at PHT index 0 starting from 11 -> counter 10, 01, 00, 00. Lookup at 0x100 becomes not-taken after the second update.
- Recovery:
  - Drive GHR to 0b00111 via speculative hits.
  - Assert mispredict with branch update_ghr_i=0b00010, taken=0, in the same cycle as a speculative hit.
  - Required: next-cycle predict_ghr_o=0b00100.
- With UCSBECE154B_BP_STATS_EN: 5 updates, 2 with mispredict_i=1 -> stat_total_o=5, stat_correct_o=3, stat_mispredict_o=2. Reset -> all three 0.
